// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// The fetch stage is the master: it drives the request and address.
interface instr_fetch_if #(
    parameter int XLEN = 64
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the multicycle core: owns PC and IR, runs one-outstanding imem fetches.
//   state | meaning
//   IDLE  | no request outstanding, buffer empty
//   WAIT  | request issued, waiting for imem_valid
//   FULL  | fetched word buffered, waiting for LoadIR
module instr_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             IMemRead,
    input  logic             PCWrite,
    input  logic             LoadIR,
    input  logic             pc_src,
    input  logic [XLEN-1:0]  branch_target,
    instr_fetch_if.master    imem,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_ir,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             fetch_busy,
    output logic             misaligned
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FULL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_ir_q, pc_ir_d;
    logic [31:0]     ir_q, ir_d;
    logic            iv_q, iv_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     buf_q, buf_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic            mis_q, mis_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_ir_d  = pc_ir_q;
        ir_d     = ir_q;
        iv_d     = iv_q;
        req_d    = req_q;
        addr_d   = addr_q;
        buf_d    = buf_q;
        buf_pc_d = buf_pc_q;
        mis_d    = 1'b0;

        // PC update is independent of the fetch FSM; a misaligned redirect is dropped
        if (PCWrite) begin
            if (!pc_src)
                pc_d = pc_q + XLEN'(4);
            else if (branch_target[1:0] == 2'b00)
                pc_d = branch_target;
            else
                mis_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (IMemRead) begin
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem.imem_valid) begin
                    buf_d    = imem.imem_rdata;
                    buf_pc_d = addr_q;
                    req_d    = 1'b0;
                    if (LoadIR) begin
                        ir_d    = imem.imem_rdata;
                        pc_ir_d = addr_q;
                        iv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (LoadIR) begin
                    ir_d    = buf_q;
                    pc_ir_d = buf_pc_q;
                    iv_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            pc_ir_q  <= RESET_PC;
            ir_q     <= NOP;
            iv_q     <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            buf_q    <= NOP;
            buf_pc_q <= RESET_PC;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_ir_q  <= pc_ir_d;
            ir_q     <= ir_d;
            iv_q     <= iv_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            mis_q    <= mis_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc             = pc_q;
    assign pc_ir          = pc_ir_q;
    assign instr          = ir_q;
    assign instr_valid    = iv_q;
    assign fetch_busy     = (state_q != ST_IDLE);
    assign misaligned     = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: latency-programmable imem model feeds a scoreboard of
// expected IR loads; control inputs are driven cycle by cycle.
module tb_instr_fetch;
    localparam int          XLEN = 64;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            IMemRead = 1'b0, PCWrite = 1'b0, LoadIR = 1'b0, pc_src = 1'b0;
    logic [XLEN-1:0] branch_target = '0;
    logic [XLEN-1:0] pc, pc_ir;
    logic [31:0]     instr;
    logic            instr_valid, fetch_busy, misaligned;

    always #5 clock = ~clock;

    instr_fetch_if #(.XLEN(XLEN)) imem();

    instr_fetch #(.XLEN(XLEN), .RESET_PC('0), .NOP(NOP)) dut (
        .clock         (clock),
        .reset         (reset),
        .IMemRead      (IMemRead),
        .PCWrite       (PCWrite),
        .LoadIR        (LoadIR),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem          (imem),
        .pc            (pc),
        .pc_ir         (pc_ir),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .fetch_busy    (fetch_busy),
        .misaligned    (misaligned)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          lat       = 1;
    bit          mem_en    = 1'b1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_data  = '0;
    int          req_count = 0;
    int          mem_cnt   = 0;
    bit          mem_busy  = 1'b0;
    logic        prev_req  = 1'b0;
    logic [63:0] held_addr = '0;
    int          rc0       = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a == 64'd0) ? 32'h0050_0093 : (a[31:0] ^ 32'h1234_5678);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_load(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, {32'd0, instr}, {32'd0, e.ins});
            chk({tag, "_pc_ir"}, pc_ir, e.pc);
            chk({tag, "_iv"}, {63'd0, instr_valid}, 64'd1);
        end
    endtask

    // Memory model: responds 'lat' cycles after the request rises, once per request
    initial begin : mem_model
        imem.imem_valid = 1'b0;
        imem.imem_rdata = '0;
        forever begin
            @(posedge clock);
            #2;
            imem.imem_valid = inj_valid;
            imem.imem_rdata = inj_data;
            if (!reset) begin
                mem_busy = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (imem.imem_req && !prev_req) begin
                    req_count++;
                    held_addr = imem.imem_addr;
                end else if (imem.imem_req) begin
                    chk("addr_stable", imem.imem_addr, held_addr);
                end
                prev_req = imem.imem_req;
                if (mem_busy)
                    mem_cnt--;
                else if (mem_en && imem.imem_req) begin
                    mem_busy = 1'b1;
                    mem_cnt  = lat - 1;
                end
                if (mem_busy && mem_cnt == 0) begin
                    imem.imem_valid = 1'b1;
                    imem.imem_rdata = mem_word(held_addr);
                    sb.push_back('{pc: held_addr, ins: mem_word(held_addr)});
                    mem_busy = 1'b0;
                end
            end
        end
    end

    initial begin : main
        tick;
        tick;
        chk("rst_pc",    pc, 64'd0);
        chk("rst_pc_ir", pc_ir, 64'd0);
        chk("rst_instr", {32'd0, instr}, {32'd0, NOP});
        chk("rst_iv",    {63'd0, instr_valid}, 64'd0);
        chk("rst_req",   {63'd0, imem.imem_req}, 64'd0);
        chk("rst_addr",  imem.imem_addr, 64'd0);
        chk("rst_busy",  {63'd0, fetch_busy}, 64'd0);
        chk("rst_mis",   {63'd0, misaligned}, 64'd0);
        reset = 1'b1;

        // zero-wait fetch with simultaneous PC advance, then load
        lat = 1;
        IMemRead = 1'b1; PCWrite = 1'b1; pc_src = 1'b0;
        tick;
        chk("t1_req",  {63'd0, imem.imem_req}, 64'd1);
        chk("t1_addr", imem.imem_addr, 64'd0);
        chk("t1_pc",   pc, 64'd4);
        IMemRead = 1'b0; PCWrite = 1'b0; LoadIR = 1'b1;
        tick;
        expect_load("t1");
        chk("t1_busy", {63'd0, fetch_busy}, 64'd0);
        chk("t1_req_drop", {63'd0, imem.imem_req}, 64'd0);
        LoadIR = 1'b0;

        // 3-cycle memory, LoadIR held, IMemRead pulses while waiting
        lat = 3;
        rc0 = req_count;
        IMemRead = 1'b1;
        tick;
        chk("t2_addr", imem.imem_addr, 64'd4);
        LoadIR = 1'b1;
        tick;
        chk("t2_busy1", {63'd0, fetch_busy}, 64'd1);
        chk("t2_hold1", {32'd0, instr}, 64'h0050_0093);
        IMemRead = 1'b0;
        tick;
        chk("t2_busy2", {63'd0, fetch_busy}, 64'd1);
        IMemRead = 1'b1;
        tick;
        expect_load("t2");
        chk("t2_busy3", {63'd0, fetch_busy}, 64'd0);
        IMemRead = 1'b0; LoadIR = 1'b0;
        tick;
        chk("t2_one_req", req_count, rc0 + 1);
        chk("t2_no_req", {63'd0, imem.imem_req}, 64'd0);

        // buffered path: response without LoadIR, PC moves while FULL
        lat = 1;
        PCWrite = 1'b1;
        tick;
        chk("t2b_pc8", pc, 64'd8);
        PCWrite = 1'b0; IMemRead = 1'b1;
        tick;
        chk("t2b_addr", imem.imem_addr, 64'd8);
        IMemRead = 1'b0; PCWrite = 1'b1;
        tick;
        chk("t2b_full_busy", {63'd0, fetch_busy}, 64'd1);
        chk("t2b_pc12", pc, 64'd12);
        chk("t2b_ir_hold", {32'd0, instr}, {32'd0, mem_word(64'd4)});
        PCWrite = 1'b0;
        tick;
        chk("t2b_still_full", {63'd0, fetch_busy}, 64'd1);
        LoadIR = 1'b1;
        tick;
        expect_load("t2b");
        LoadIR = 1'b0;

        // aligned redirect, then fetch from the target while PC keeps moving
        PCWrite = 1'b1; pc_src = 1'b1; branch_target = 64'h80;
        tick;
        chk("t3_pc", pc, 64'h80);
        chk("t3_mis", {63'd0, misaligned}, 64'd0);
        lat = 3;
        IMemRead = 1'b1; pc_src = 1'b0;
        tick;
        chk("t3_addr", imem.imem_addr, 64'h80);
        chk("t3_pc84", pc, 64'h84);
        IMemRead = 1'b0;
        tick;
        chk("t3_pc88", pc, 64'h88);
        chk("t3_addr_hold", imem.imem_addr, 64'h80);
        PCWrite = 1'b0; LoadIR = 1'b1;
        tick;
        chk("t3_busy", {63'd0, fetch_busy}, 64'd1);
        tick;
        expect_load("t3");
        LoadIR = 1'b0;

        // misaligned redirect
        PCWrite = 1'b1; pc_src = 1'b1; branch_target = 64'h82;
        tick;
        chk("t4_pc", pc, 64'h88);
        chk("t4_mis_hi", {63'd0, misaligned}, 64'd1);
        PCWrite = 1'b0;
        tick;
        chk("t4_mis_lo", {63'd0, misaligned}, 64'd0);
        chk("t4_pc_keep", pc, 64'h88);

        // PC wrap
        PCWrite = 1'b1; pc_src = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick;
        chk("t5_pc_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        pc_src = 1'b0;
        tick;
        chk("t5_wrap", pc, 64'd0);
        PCWrite = 1'b0;

        // reset while waiting, then a stale response after release
        lat = 3;
        IMemRead = 1'b1;
        tick;
        chk("t6_req", {63'd0, imem.imem_req}, 64'd1);
        IMemRead = 1'b0;
        tick;
        reset = 1'b0;
        mem_en = 1'b0;
        #1;
        chk("t6_async_req",  {63'd0, imem.imem_req}, 64'd0);
        chk("t6_async_busy", {63'd0, fetch_busy}, 64'd0);
        chk("t6_async_pc",   pc, 64'd0);
        chk("t6_async_iv",   {63'd0, instr_valid}, 64'd0);
        chk("t6_async_ir",   {32'd0, instr}, {32'd0, NOP});
        tick;
        reset = 1'b1;
        inj_valid = 1'b1; inj_data = 32'hDEAD_BEEF; LoadIR = 1'b1;
        tick;
        inj_valid = 1'b0; LoadIR = 1'b0;
        chk("t6_ir",   {32'd0, instr}, {32'd0, NOP});
        chk("t6_iv",   {63'd0, instr_valid}, 64'd0);
        chk("t6_busy", {63'd0, fetch_busy}, 64'd0);
        tick;
        chk("t6_idle", {63'd0, fetch_busy}, 64'd0);
        chk("t6_no_req", {63'd0, imem.imem_req}, 64'd0);

        chk("sb_empty", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
